// File: rtl/fb_pkg.sv
// Shared constants and helpers for the framebuffer scan-out arbiter:
// framebuffer geometry, 640x480@60 VGA timing totals, read lead and slot encoding.
package fb_pkg;

  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int PIX_W     = 12;
  localparam int ADDR_W    = 17;

  localparam int H_VISIBLE = 640;
  localparam int H_TOTAL   = 800;
  localparam int V_VISIBLE = 480;
  localparam int V_TOTAL   = 525;
  localparam int CNT_W     = 10;

  // Reads are issued this many pixel clocks ahead of the pixel they feed
  // (one cycle of RAM latency plus one cycle for the pix_data register).
  localparam int LEAD      = 2;

  // What the RAM port is doing in a given cycle.
  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_READ  = 2'd1,
    SLOT_WRITE = 2'd2
  } slot_e;

  // A raster position of the timing generator.
  typedef struct packed {
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
  } scan_pos_t;

  // Advance a raster position by one pixel clock, wrapping at line and frame end.
  function automatic scan_pos_t scan_step(input scan_pos_t p);
    scan_pos_t r;
    r = p;
    if (p.h == CNT_W'(H_TOTAL - 1)) begin
      r.h = '0;
      r.v = (p.v == CNT_W'(V_TOTAL - 1)) ? '0 : p.v + CNT_W'(1);
    end else begin
      r.h = p.h + CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fb_write_skid.sv
// One-entry holding register for the image-pipeline writer.
// Accepts an entry via load (only while empty) and releases it on drain,
// which is pulsed during the cycle the entry is being written to RAM.
// The pend_* outputs show what the buffer will hold in the next cycle,
// letting the arbiter schedule a write slot one cycle ahead.
module fb_write_skid
  import fb_pkg::*;
#(
  parameter int ADDR_W = fb_pkg::ADDR_W,
  parameter int PIX_W  = fb_pkg::PIX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [PIX_W-1:0]  load_data,
  input  logic              drain,
  output logic              full,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_addr,
  output logic [PIX_W-1:0]  pend_data
);

  logic              full_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [PIX_W-1:0]  data_reg;

  // Capture on load, empty on drain; reset discards any pending entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_reg <= 1'b0;
      addr_reg <= '0;
      data_reg <= '0;
    end else if (load) begin
      full_reg <= 1'b1;
      addr_reg <= load_addr;
      data_reg <= load_data;
    end else if (drain) begin
      full_reg <= 1'b0;
    end
  end

  assign full       = full_reg;
  assign pend_valid = load | (full_reg & ~drain);
  assign pend_addr  = load ? load_addr : addr_reg;
  assign pend_data  = load ? load_data : data_reg;

endmodule

// File: rtl/fb_scan_arbiter.sv
// Single-port framebuffer arbiter: VGA scan-out reads (320x240 shown 2x)
// take every slot they need; the writer fills the remaining ones through a
// one-entry skid buffer. All RAM-side outputs are registers, so each slot is
// decided one cycle early from the predicted next raster position.
module fb_scan_arbiter
  import fb_pkg::*;
#(
  parameter int FB_W           = fb_pkg::FB_W,
  parameter int FB_H           = fb_pkg::FB_H,
  parameter int PIX_W          = fb_pkg::PIX_W,
  parameter int ADDR_W         = fb_pkg::ADDR_W,
  parameter bit WR_VBLANK_ONLY = 1'b0
) (
  input  logic              clk_vga,
  input  logic              reset,
  input  logic [CNT_W-1:0]  h_count,
  input  logic [CNT_W-1:0]  v_count,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  pix_data,
  output logic              in_vblank,
  output logic              wr_addr_err
);

  localparam logic [ADDR_W-1:0] FB_W_BITS = ADDR_W'(FB_W);
  localparam logic [ADDR_W-1:0] FB_SIZE   = ADDR_W'(FB_W * FB_H);

  // ---------------------------------------------------------------------
  // Raster prediction: next_pos is where the generator will be in the
  // cycle the registered outputs apply to; la_pos is LEAD clocks beyond.
  // ---------------------------------------------------------------------
  scan_pos_t cur_pos;
  scan_pos_t next_pos;
  scan_pos_t la_pos;
  scan_pos_t la_chain [LEAD+1];
  logic      in_range;

  assign cur_pos     = '{h: h_count, v: v_count};
  assign in_range    = (h_count < CNT_W'(H_TOTAL)) && (v_count < CNT_W'(V_TOTAL));
  assign next_pos    = scan_step(cur_pos);
  assign la_chain[0] = next_pos;

  for (genvar gi = 0; gi < LEAD; gi++) begin : g_lead
    assign la_chain[gi+1] = scan_step(la_chain[gi]);
  end

  assign la_pos = la_chain[LEAD];

  // Pixel LEAD clocks ahead is visible; even columns start a 2x-wide pixel.
  logic la_visible;
  logic read_slot;

  assign la_visible = in_range && (la_pos.h < CNT_W'(H_VISIBLE)) &&
                      (la_pos.v < CNT_W'(V_VISIBLE));
  assign read_slot  = la_visible && !la_pos.h[0];

  // ---------------------------------------------------------------------
  // Read address (y*FB_W + x) built from shifted copies of y, one per set
  // bit of FB_W, so no multiplier is needed.
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] fb_x;
  logic [ADDR_W-1:0] fb_y;
  logic [ADDR_W-1:0] pp [ADDR_W];
  logic [ADDR_W-1:0] rd_addr;

  assign fb_x = ADDR_W'(la_pos.h >> 1);
  assign fb_y = ADDR_W'(la_pos.v >> 1);

  for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_pp
    assign pp[gi] = FB_W_BITS[gi] ? (fb_y << gi) : '0;
  end

  // Sum the partial products on top of the column offset.
  always_comb begin
    rd_addr = fb_x;
    for (int i = 0; i < ADDR_W; i++) begin
      rd_addr = rd_addr + pp[i];
    end
  end

  // ---------------------------------------------------------------------
  // Writer side: out-of-range addresses are accepted but never stored.
  // ---------------------------------------------------------------------
  logic              skid_full;
  logic              accept;
  logic              addr_ok;
  logic              skid_load;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [PIX_W-1:0]  pend_data;
  logic              vblank_next;
  logic              write_slot;

  logic              mem_en_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [PIX_W-1:0]  mem_wdata_reg;
  slot_e             slot_reg;

  assign accept    = wr_valid && !skid_full;
  assign addr_ok   = wr_addr < FB_SIZE;
  assign skid_load = accept && addr_ok;

  fb_write_skid #(
    .ADDR_W (ADDR_W),
    .PIX_W  (PIX_W)
  ) u_skid (
    .clk        (clk_vga),
    .reset      (reset),
    .load       (skid_load),
    .load_addr  (wr_addr),
    .load_data  (wr_data),
    .drain      (mem_we_reg),
    .full       (skid_full),
    .pend_valid (pend_valid),
    .pend_addr  (pend_addr),
    .pend_data  (pend_data)
  );

  // Writes only ever take cycles that scan-out does not need.
  assign vblank_next = next_pos.v >= CNT_W'(V_VISIBLE);
  assign write_slot  = pend_valid && !read_slot && (!WR_VBLANK_ONLY || vblank_next);

  // Slot FSM: load the RAM port registers for the coming cycle.
  always_ff @(posedge clk_vga) begin
    if (reset) begin
      slot_reg      <= SLOT_IDLE;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else if (read_slot) begin
      slot_reg      <= SLOT_READ;
      mem_en_reg    <= 1'b1;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= rd_addr;
    end else if (write_slot) begin
      slot_reg      <= SLOT_WRITE;
      mem_en_reg    <= 1'b1;
      mem_we_reg    <= 1'b1;
      mem_addr_reg  <= pend_addr;
      mem_wdata_reg <= pend_data;
    end else begin
      slot_reg      <= SLOT_IDLE;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Pixel output pipeline: the visibility flag travels with the read so
  // pix_data lines up with the pixel the generator is showing.
  // ---------------------------------------------------------------------
  logic             vis_reg;
  logic             vis_d_reg;
  logic             rd_d_reg;
  logic [PIX_W-1:0] pix_reg;

  // Carry visibility/read flags alongside the RAM latency and capture pixels.
  always_ff @(posedge clk_vga) begin
    if (reset) begin
      vis_reg   <= 1'b0;
      vis_d_reg <= 1'b0;
      rd_d_reg  <= 1'b0;
      pix_reg   <= '0;
    end else begin
      vis_reg   <= la_visible;
      vis_d_reg <= vis_reg;
      rd_d_reg  <= (slot_reg == SLOT_READ);
      if (!vis_d_reg) begin
        pix_reg <= '0;
      end else if (rd_d_reg) begin
        pix_reg <= mem_rdata;
      end
    end
  end

  logic in_vblank_reg;
  logic wr_addr_err_reg;

  // Vertical-blank flag and sticky bad-address flag.
  always_ff @(posedge clk_vga) begin
    if (reset) begin
      in_vblank_reg   <= 1'b0;
      wr_addr_err_reg <= 1'b0;
    end else begin
      in_vblank_reg   <= v_count >= CNT_W'(V_VISIBLE);
      wr_addr_err_reg <= wr_addr_err_reg | (accept && !addr_ok);
    end
  end

  assign wr_ready    = !skid_full;
  assign mem_en      = mem_en_reg;
  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign pix_data    = pix_reg;
  assign in_vblank   = in_vblank_reg;
  assign wr_addr_err = wr_addr_err_reg;

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Directed bench for fb_scan_arbiter: behavioural 1-cycle-latency RAM,
// a steppable timing generator, table-driven scan vectors and hand-written
// sequences for streaming writes, bad addresses, vblank-only writes and reset.
module tb_fb_scan_arbiter;

  localparam int FBN = 76800;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  h_count;
  logic [9:0]  v_count;

  logic        wr_valid, wr_ready;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        mem_en, mem_we;
  logic [16:0] mem_addr;
  logic [11:0] mem_wdata, mem_rdata, pix_data;
  logic        in_vblank, wr_addr_err;

  logic        vb_wr_valid, vb_wr_ready;
  logic [16:0] vb_wr_addr;
  logic [11:0] vb_wr_data;
  logic        vb_mem_en, vb_mem_we;
  logic [16:0] vb_mem_addr;
  logic [11:0] vb_mem_wdata, vb_mem_rdata, vb_pix_data;
  logic        vb_in_vblank, vb_wr_addr_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign vb_mem_rdata = 12'h000;

  fb_scan_arbiter dut (
    .clk_vga(clk), .reset(reset), .h_count(h_count), .v_count(v_count),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix_data(pix_data), .in_vblank(in_vblank),
    .wr_addr_err(wr_addr_err)
  );

  fb_scan_arbiter #(.WR_VBLANK_ONLY(1'b1)) dut_vb (
    .clk_vga(clk), .reset(reset), .h_count(h_count), .v_count(v_count),
    .wr_valid(vb_wr_valid), .wr_ready(vb_wr_ready), .wr_addr(vb_wr_addr), .wr_data(vb_wr_data),
    .mem_en(vb_mem_en), .mem_we(vb_mem_we), .mem_addr(vb_mem_addr), .mem_wdata(vb_mem_wdata),
    .mem_rdata(vb_mem_rdata), .pix_data(vb_pix_data), .in_vblank(vb_in_vblank),
    .wr_addr_err(vb_wr_addr_err)
  );

  // Behavioural RAM, preloaded with mem[y*320+x] = (y<<6|x) on the first edge.
  logic [11:0] ram [FBN];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int y = 0; y < 240; y++)
        for (int x = 0; x < 320; x++)
          ram[y*320+x] <= 12'((y << 6) | x);
      loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Advance the timing generator one pixel clock (inputs change 1 after the edge).
  task automatic step();
    @(posedge clk); #1;
    if (h_count == 10'd799) begin
      h_count = 10'd0;
      v_count = (v_count == 10'd524) ? 10'd0 : v_count + 10'd1;
    end else begin
      h_count = h_count + 10'd1;
    end
  endtask

  // Jump the generator so that it arrives at (th,tv) after six free-running clocks.
  task automatic goto(input int th, input int tv);
    int idx;
    idx = (tv * 800 + th + 420000 - 6) % 420000;
    @(posedge clk); #1;
    h_count = 10'(idx % 800);
    v_count = 10'(idx / 800);
    repeat (6) step();
  endtask

  // Expected read slot for the current generator position.
  function automatic bit ref_read(input int h, input int v, output int addr);
    int hl, vl;
    hl = (h + 2) % 800;
    vl = (h >= 798) ? (v + 1) % 525 : v;
    addr = (vl / 2) * 320 + hl / 2;
    return (hl < 640) && (vl < 480) && (hl % 2 == 0);
  endfunction

  function automatic int wdat(input int i);
    return (i * 37 + 5) & 12'hFFF;
  endfunction

  typedef struct {
    int h; int v; bit en; int addr; int pix; bit vb;
  } vec_t;
  vec_t vecs [13];

  initial begin
    int ea, n_acc, n_we, saw, found, fa, fd, fh, fv;
    bit er;

    vecs[0]  = '{h:0,   v:0,   en:1, addr:1,     pix:0,    vb:1};
    vecs[1]  = '{h:2,   v:0,   en:1, addr:2,     pix:1,    vb:0};
    vecs[2]  = '{h:1,   v:0,   en:0, addr:0,     pix:0,    vb:0};
    vecs[3]  = '{h:798, v:524, en:1, addr:0,     pix:0,    vb:1};
    vecs[4]  = '{h:798, v:479, en:0, addr:0,     pix:0,    vb:0};
    vecs[5]  = '{h:100, v:50,  en:1, addr:8051,  pix:1650, vb:0};
    vecs[6]  = '{h:101, v:50,  en:0, addr:0,     pix:1650, vb:0};
    vecs[7]  = '{h:636, v:10,  en:1, addr:1919,  pix:382,  vb:0};
    vecs[8]  = '{h:638, v:10,  en:0, addr:0,     pix:383,  vb:0};
    vecs[9]  = '{h:798, v:100, en:1, addr:16000, pix:0,    vb:0};
    vecs[10] = '{h:799, v:100, en:0, addr:0,     pix:0,    vb:0};
    vecs[11] = '{h:2,   v:479, en:1, addr:76482, pix:3009, vb:0};
    vecs[12] = '{h:300, v:500, en:0, addr:0,     pix:0,    vb:1};

    reset = 1'b1;
    h_count = 10'd100; v_count = 10'd500;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    vb_wr_valid = 1'b0; vb_wr_addr = '0; vb_wr_data = '0;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_pix", pix_data, 0);
    check("rst_in_vblank", in_vblank, 0);
    check("rst_err", wr_addr_err, 0);
    check("rst_wr_ready", wr_ready, 1);
    step();
    reset = 1'b0;

    // Table-driven scan vectors
    for (int i = 0; i < 13; i++) begin
      goto(vecs[i].h, vecs[i].v);
      @(negedge clk);
      $display("vec %0d h=%0d v=%0d en=%0d we=%0d addr=%0d pix=%0d vb=%0d",
               i, h_count, v_count, mem_en, mem_we, mem_addr, pix_data, in_vblank);
      check($sformatf("vec%0d_en", i), mem_en, vecs[i].en);
      check($sformatf("vec%0d_we", i), mem_we, 0);
      if (vecs[i].en) check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].addr);
      check($sformatf("vec%0d_pix", i), pix_data, vecs[i].pix);
      check($sformatf("vec%0d_vblank", i), in_vblank, vecs[i].vb);
    end

    // Streaming writes during active scan: reads keep every slot
    goto(0, 20);
    n_acc = 0; n_we = 0;
    wr_valid = 1'b1; wr_addr = 17'd2000; wr_data = 12'(wdat(0));
    for (int c = 0; c < 1500 && n_we < 200; c++) begin
      @(negedge clk);
      if (ref_read(h_count, v_count, ea)) begin
        check("stream_read_slot", {30'd0, mem_en, mem_we}, 2);
        check("stream_read_addr", mem_addr, ea);
      end else if (mem_we) begin
        check("stream_wr_addr", mem_addr, 2000 + n_we);
        check("stream_wr_data", mem_wdata, wdat(n_we));
        n_we++;
      end
      if (wr_valid && wr_ready) n_acc++;
      step();
      wr_valid = (n_acc < 200);
      wr_addr = 17'(2000 + n_acc);
      wr_data = 12'(wdat(n_acc));
    end
    wr_valid = 1'b0;
    $display("stream writes issued=%0d accepted=%0d", n_we, n_acc);
    check("stream_write_count", n_we, 200);
    step();
    for (int i = 0; i < 200; i++) check($sformatf("stream_ram%0d", i), ram[2000+i], wdat(i));

    // Out-of-range address: accepted, dropped, sticky error
    goto(100, 490);
    wr_valid = 1'b1; wr_addr = 17'd76800; wr_data = 12'h123;
    @(negedge clk);
    check("bad_ready_before", wr_ready, 1);
    step();
    wr_valid = 1'b0;
    saw = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_we) saw = 1;
      step();
    end
    @(negedge clk);
    $display("bad addr: we_seen=%0d err=%0d ready=%0d", saw, wr_addr_err, wr_ready);
    check("bad_no_write", saw, 0);
    check("bad_err_set", wr_addr_err, 1);
    check("bad_ready_after", wr_ready, 1);
    step();
    wr_valid = 1'b1; wr_addr = 17'd7; wr_data = 12'hABC;
    @(negedge clk);
    step();
    wr_valid = 1'b0;
    found = 0; fa = 0; fd = 0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clk);
      if (mem_we) begin found = 1; fa = mem_addr; fd = mem_wdata; end
      step();
    end
    $display("legal after bad: found=%0d addr=%0d data=%0h", found, fa, fd);
    check("legal_found", found, 1);
    check("legal_addr", fa, 7);
    check("legal_data", fd, 12'hABC);
    @(negedge clk);
    check("err_sticky", wr_addr_err, 1);
    check("legal_ram", ram[7], 12'hABC);

    // Vblank-only instance: write held from v=100 until the first line of vblank
    goto(100, 100);
    vb_wr_valid = 1'b1; vb_wr_addr = 17'd300; vb_wr_data = 12'h5C3;
    @(negedge clk);
    check("vb_ready_before", vb_wr_ready, 1);
    step();
    vb_wr_valid = 1'b0;
    @(negedge clk);
    check("vb_ready_drops", vb_wr_ready, 0);
    saw = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      @(negedge clk);
      if (vb_mem_we) saw = 1;
    end
    check("vb_no_write_active", saw, 0);
    goto(790, 479);
    found = 0; fh = 0; fv = 0; fa = 0; fd = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (vb_mem_we && vb_mem_en) begin
        found = 1; fh = h_count; fv = v_count; fa = vb_mem_addr; fd = vb_mem_wdata;
      end else begin
        step();
      end
    end
    $display("vb write: found=%0d at h=%0d v=%0d addr=%0d data=%0h", found, fh, fv, fa, fd);
    check("vb_write_found", found, 1);
    check("vb_write_v", fv, 480);
    check("vb_write_h", fh, 0);
    check("vb_write_addr", fa, 300);
    check("vb_write_data", fd, 12'h5C3);
    step();
    @(negedge clk);
    check("vb_ready_back", vb_wr_ready, 1);
    check("vb_err_clear", vb_wr_addr_err, 0);

    // Reset with a full skid at h=300,v=200
    goto(290, 200);
    vb_wr_valid = 1'b1; vb_wr_addr = 17'd400; vb_wr_data = 12'h111;
    @(negedge clk);
    step();
    vb_wr_valid = 1'b0;
    repeat (9) step();
    @(negedge clk);
    check("pre_rst_pix", pix_data, 2454);
    check("pre_rst_vb_full", vb_wr_ready, 0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    $display("after reset h=%0d: vb_ready=%0d pix=%0d err=%0d", h_count, vb_wr_ready, pix_data, wr_addr_err);
    check("rst_mid_vb_ready", vb_wr_ready, 1);
    check("rst_mid_pix", pix_data, 0);
    check("rst_mid_err_clear", wr_addr_err, 0);
    goto(780, 479);
    saw = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (vb_mem_we) saw = 1;
      step();
    end
    check("rst_mid_write_discarded", saw, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
